spi_frame_slave: RTL

Parametrised SPI slave for the motor-controller command path. It supports all four SPI modes and a configurable word width. It has a full-duplex shift engine with a one-word transmit buffer, per-word receive strobes and underrun/abort status. It sits between the chip-level `sclk`/`mosi`/`ss_n`/`miso` pads and the register/command logic, and runs entirely in the system `clock` domain with oversampled SPI inputs.

---
 rtl/spi_frame_slave_if.sv | 41 ++++
 rtl/spi_frame_slave.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/spi_frame_slave_if.sv
// Bus bundle for spi_frame_slave: SPI pads plus the word-level tx/rx handshake.
// SPI_FRAME_LSB_FIRST_EN adds the lsb_first select.
interface spi_frame_slave_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  sclk;
  logic                  ss_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oeb;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  frame_active;
  logic                  tx_underrun;
  logic                  frame_abort;
`ifdef SPI_FRAME_LSB_FIRST_EN
  logic                  lsb_first;
`endif

  modport slave (
`ifdef SPI_FRAME_LSB_FIRST_EN
    input  lsb_first,
`endif
    input  sclk, ss_n, mosi, mode, tx_data, tx_load,
    output miso, miso_oeb, tx_ready, rx_data, rx_valid,
    output frame_active, tx_underrun, frame_abort
  );

  modport master (
`ifdef SPI_FRAME_LSB_FIRST_EN
    output lsb_first,
`endif
    output sclk, ss_n, mosi, mode, tx_data, tx_load,
    input  miso, miso_oeb, tx_ready, rx_data, rx_valid,
    input  frame_active, tx_underrun, frame_abort
  );
endinterface

// File: rtl/spi_frame_slave.sv
// SPI slave, all four modes, oversampled in the system clock domain, one-word tx buffer.
// Optional SPI_FRAME_LSB_FIRST_EN adds an LSB-first mode latched at frame start.
module spi_frame_slave #(
  parameter int DATA_WIDTH = 32
) (
  input logic              clock,
  input logic              reset_n,
  spi_frame_slave_if.slave bus
);
  localparam int                CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]     LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                state_q, state_d;
  logic [2:0]            sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic [1:0]            mode_q, mode_d;
  logic                  lsb_q, lsb_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  hold_q, hold_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  abort_q, abort_d;

  logic                  sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic                  leading_edge, trailing_edge, sample_edge, shift_edge;
  logic                  mosi_bit, reload;
  logic [DATA_WIDTH-1:0] rx_next, tx_next;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
  assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
  // Data is stable for several clocks around each sample edge, so the oldest tap is safe.
  assign mosi_bit  = mosi_sync_q[2];

  assign leading_edge  = mode_q[1] ? sclk_fall : sclk_rise;
  assign trailing_edge = mode_q[1] ? sclk_rise : sclk_fall;
  assign sample_edge   = mode_q[0] ? trailing_edge : leading_edge;
  assign shift_edge    = mode_q[0] ? leading_edge : trailing_edge;

  assign rx_next = lsb_q ? {mosi_bit, rx_shift_q[DATA_WIDTH-1:1]}
                         : {rx_shift_q[DATA_WIDTH-2:0], mosi_bit};
  assign tx_next = lsb_q ? {1'b0, tx_shift_q[DATA_WIDTH-1:1]}
                         : {tx_shift_q[DATA_WIDTH-2:0], 1'b0};

  // NOTE: every variable gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lsb_d      = lsb_q;
    bit_cnt_d  = bit_cnt_q;
    hold_d     = hold_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    tx_buf_d   = tx_buf_q;
    rx_data_d  = rx_data_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    abort_d    = 1'b0;
    reload     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = ACTIVE;
          mode_d    = bus.mode;
`ifdef SPI_FRAME_LSB_FIRST_EN
          lsb_d     = bus.lsb_first;
`else
          lsb_d     = 1'b0;
`endif
          bit_cnt_d = '0;
          hold_d    = bus.mode[0];
          reload    = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_q != '0) begin
            abort_d    = 1'b1;
            rx_shift_d = '0;
          end
          bit_cnt_d = '0;
        end else if (sample_edge) begin
          rx_shift_d = rx_next;
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            reload     = 1'b1;
            hold_d     = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (shift_edge) begin
          // The first shift edge after a reload must keep the fresh word's first bit on miso.
          if (hold_q) hold_d = 1'b0;
          else        tx_shift_d = tx_next;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reload) begin
      if (!tx_ready_q) begin
        tx_shift_d = tx_buf_q;
        tx_ready_d = 1'b1;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end

    // Gated on the registered flag: a load coincident with a reload from a full buffer is dropped.
    if (bus.tx_load && tx_ready_q) begin
      tx_buf_d   = bus.tx_data;
      tx_ready_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sclk_sync_q <= 3'b000;
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 3'b000;
      mode_q      <= 2'b00;
      lsb_q       <= 1'b0;
      bit_cnt_q   <= '0;
      hold_q      <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      tx_buf_q    <= '0;
      rx_data_q   <= '0;
      tx_ready_q  <= 1'b1;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[1:0], bus.sclk};
      ss_sync_q   <= {ss_sync_q[1:0], bus.ss_n};
      mosi_sync_q <= {mosi_sync_q[1:0], bus.mosi};
      mode_q      <= mode_d;
      lsb_q       <= lsb_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      tx_buf_q    <= tx_buf_d;
      rx_data_q   <= rx_data_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.miso         = lsb_q ? tx_shift_q[0] : tx_shift_q[DATA_WIDTH-1];
  assign bus.miso_oeb     = (state_q != ACTIVE);
  assign bus.frame_active = (state_q == ACTIVE);
  assign bus.tx_ready     = tx_ready_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.tx_underrun  = underrun_q;
  assign bus.frame_abort  = abort_q;
endmodule
